// File: rtl/piso_shift_register_if.sv
// Word-in / bit-out handshake bundle for piso_shift_register.
// slave = the shift register; master = its environment (word source plus bit sink).
interface piso_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic [WIDTH-1:0] d_i;
  logic             ready_o;
  logic             sdata_o;
  logic             svalid_o;
  logic             sready_i;
  logic             last_o;
  logic             busy_o;

  modport master (
    output valid_i, d_i, sready_i,
    input  ready_o, sdata_o, svalid_o, last_o, busy_o
  );

  modport slave (
    input  valid_i, d_i, sready_i,
    output ready_o, sdata_o, svalid_o, last_o, busy_o
  );
endinterface

// File: rtl/piso_shift_register.sv
// Parallel-in, serial-out transmitter: captures one WIDTH-bit word, then emits it a bit per accepted beat.
// Optional feature macro PISO_PARITY_EN appends an even-parity bit carrying last_o.
module piso_shift_register #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic  clk,
  input  logic  rst_n,
  piso_if.slave bus
);
  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic             capture;
  logic             beat;
  logic             last_beat;

  // rst_n is active-high here: the block is held in reset while it is 1.
  assign capture   = (state == IDLE) && bus.valid_i && !rst_n;
  assign beat      = (state == SHIFT) && bus.sready_i;
  assign last_beat = beat && (cnt == CNT_LAST);

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) return {v[WIDTH-2:0], 1'b0};
    else           return {1'b0, v[WIDTH-1:1]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst_n) state <= IDLE;
    else       state <= state_nxt;
  end

  // cnt stops at CNT_LAST so it never wraps inside a frame; capture reloads it.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (capture) begin
      shreg <= bus.d_i;
      cnt   <= '0;
    end else if (beat) begin
      shreg <= shift_out(shreg);
      if (cnt != CNT_LAST) cnt <= cnt + CNT_W'(1);
    end
  end

`ifdef PISO_PARITY_EN
  logic par;

  always_ff @(posedge clk) begin
    if (rst_n)        par <= 1'b0;
    else if (capture) par <= ^bus.d_i;
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (capture) state_nxt = SHIFT;
`ifdef PISO_PARITY_EN
      SHIFT:  if (last_beat) state_nxt = PARITY;
      PARITY: if (bus.sready_i) state_nxt = IDLE;
`else
      SHIFT:  if (last_beat) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.ready_o  = 1'b0;
    bus.svalid_o = 1'b0;
    bus.sdata_o  = 1'b0;
    bus.last_o   = 1'b0;
    bus.busy_o   = 1'b0;
    case (state)
      IDLE: bus.ready_o = !rst_n;
      SHIFT: begin
        bus.svalid_o = 1'b1;
        bus.busy_o   = 1'b1;
        bus.sdata_o  = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
`ifndef PISO_PARITY_EN
        bus.last_o   = (cnt == CNT_LAST);
`endif
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        bus.svalid_o = 1'b1;
        bus.busy_o   = 1'b1;
        bus.sdata_o  = par;
        bus.last_o   = 1'b1;
      end
`endif
      default: ;
    endcase
  end
endmodule

// File: tb/tb_piso_shift_register.sv
// Bench for piso_shift_register: MSB-first and LSB-first instances share stimulus and a queue-based reference.
module tb_piso_shift_register;
  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic         clk;
  logic         rst;
  logic         valid;
  logic [W-1:0] d;
  logic         sready;
  int           total = 0;
  int           bad   = 0;

  piso_if #(.WIDTH(W)) ifm ();
  piso_if #(.WIDTH(W)) ifl ();

  assign ifm.valid_i  = valid;
  assign ifm.d_i      = d;
  assign ifm.sready_i = sready;
  assign ifl.valid_i  = valid;
  assign ifl.d_i      = d;
  assign ifl.sready_i = sready;

  piso_shift_register #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst_n(rst), .bus(ifm.slave));
  piso_shift_register #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst_n(rst), .bus(ifl.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the bits still owed for the current frame, in wire order, for each bit ordering.
  bit mq_m[$];
  bit mq_l[$];

  always @(posedge clk) begin
    if (rst) begin
      mq_m.delete();
      mq_l.delete();
    end else if (mq_m.size() == 0) begin
      if (valid) begin
        for (int i = W - 1; i >= 0; i--) mq_m.push_back(d[i]);
        for (int i = 0; i < W; i++)      mq_l.push_back(d[i]);
`ifdef PISO_PARITY_EN
        mq_m.push_back(^d);
        mq_l.push_back(^d);
`endif
      end
    end else if (sready) begin
      void'(mq_m.pop_front());
      void'(mq_l.pop_front());
    end
  end

  function automatic logic [9:0] obs_vec();
    return {ifm.ready_o, ifm.svalid_o, ifm.last_o, ifm.busy_o, ifm.sdata_o,
            ifl.ready_o, ifl.svalid_o, ifl.last_o, ifl.busy_o, ifl.sdata_o};
  endfunction

  function automatic logic [9:0] exp_vec();
    logic act, r, lst, dm, dl;
    act = (mq_m.size() != 0);
    r   = !act && !rst;
    lst = (mq_m.size() == 1);
    dm  = act ? mq_m[0] : 1'b0;
    dl  = act ? mq_l[0] : 1'b0;
    return {r, act, lst, act, dm, r, act, lst, act, dl};
  endfunction

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; sready = 1'b1; d = '0;
    cycle();
    total++;
    if (obs_vec() !== 10'b0) begin
      bad++;
      $display("FAIL reset_hold outputs=%b required=%b", obs_vec(), 10'b0);
    end
    rst = 1'b0;
    cycle();
    total++;
    if (obs_vec() !== 10'b10000_10000) begin
      bad++;
      $display("FAIL reset_release outputs=%b required=%b", obs_vec(), 10'b10000_10000);
    end
  endtask

  task automatic test_frame(input logic [W-1:0] w, input int stall_at, input int stall_len);
    bit bm[$];
    bit bl[$];
    int cyc = 0, stalled = 0, lasts = 0, last_idx = -1;
    logic [W-1:0] accm = '0, accl = '0;
    valid = 1'b1; d = w; sready = 1'b1;
    cycle();
    valid = 1'b0;
    while (mq_m.size() != 0 && cyc < 40) begin
      if (stall_at >= 0 && bm.size() == stall_at && stalled < stall_len) begin
        sready = 1'b0; stalled++;
      end else sready = 1'b1;
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL frame_%h cyc%0d outputs=%b required=%b", w, cyc, obs_vec(), exp_vec());
      end
      if (ifm.svalid_o && sready) begin
        if (ifm.last_o) begin lasts++; last_idx = bm.size(); end
        bm.push_back(ifm.sdata_o);
        bl.push_back(ifl.sdata_o);
      end
      cycle();
      cyc++;
    end
    sready = 1'b1;
    total++;
    if (cyc !== FRAME + stall_len || bm.size() !== FRAME) begin
      bad++;
      $display("FAIL frame_%h_len cycles=%0d bits=%0d required=%0d", w, cyc, bm.size(), FRAME + stall_len);
    end else begin
      for (int i = 0; i < W; i++) accm = {accm[W-2:0], bm[i]};
      for (int i = 0; i < W; i++) accl[i] = bl[i];
      total++;
      if (accm !== w || accl !== w) begin
        bad++;
        $display("FAIL frame_%h_bits msb_got=%h lsb_got=%h required=%h", w, accm, accl, w);
      end
`ifdef PISO_PARITY_EN
      total++;
      if (bm[W] !== ^w || bl[W] !== ^w) begin
        bad++;
        $display("FAIL frame_%h_parity got=%b/%b required=%b", w, bm[W], bl[W], ^w);
      end
`endif
    end
    total++;
    if (lasts !== 1 || last_idx !== FRAME - 1) begin
      bad++;
      $display("FAIL frame_%h_last count=%0d at=%0d required=1 at %0d", w, lasts, last_idx, FRAME - 1);
    end
    total++;
    if (ifm.ready_o !== 1'b1 || ifl.ready_o !== 1'b1) begin
      bad++;
      $display("FAIL frame_%h_ready got=%b%b required=11", w, ifm.ready_o, ifl.ready_o);
    end
  endtask

  task automatic test_back_to_back();
    bit got[$];
    bit want[$];
    logic [W-1:0] words [2];
    int cyc = 0, gap_at = -1;
    words[0] = 8'hC1; words[1] = 8'h55;
    for (int k = 0; k < 2; k++) begin
      for (int i = W - 1; i >= 0; i--) want.push_back(words[k][i]);
`ifdef PISO_PARITY_EN
      want.push_back(^words[k]);
`endif
    end
    valid = 1'b1; d = 8'hC1; sready = 1'b1;
    cycle();
    d = 8'h55;
    while ((mq_m.size() != 0 || valid) && cyc < 60) begin
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL b2b cyc%0d outputs=%b required=%b", cyc, obs_vec(), exp_vec());
      end
      if (ifm.svalid_o) got.push_back(ifm.sdata_o);
      if (ifm.ready_o && valid && gap_at < 0) gap_at = cyc;
      cycle();
      if (gap_at >= 0) valid = 1'b0;
      cyc++;
    end
    total++;
    if (gap_at !== FRAME || got != want) begin
      bad++;
      $display("FAIL b2b_stream second_capture_cycle=%0d required=%0d bits=%0d required=%0d",
               gap_at, FRAME, got.size(), want.size());
    end
  endtask

  task automatic test_reset_midframe();
    int lasts = 0;
    valid = 1'b1; d = 8'hFF; sready = 1'b1;
    cycle();
    valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL midrst_bit%0d outputs=%b required=%b", i, obs_vec(), exp_vec());
      end
      if (ifm.last_o || ifl.last_o) lasts++;
      cycle();
    end
    rst = 1'b1;
    cycle();
    total++;
    if (obs_vec() !== 10'b0) begin
      bad++;
      $display("FAIL midrst_hold outputs=%b required=%b", obs_vec(), 10'b0);
    end
    rst = 1'b0;
    cycle();
    total++;
    if (obs_vec() !== 10'b10000_10000 || lasts !== 0) begin
      bad++;
      $display("FAIL midrst_release outputs=%b lasts=%0d required=%b lasts=0", obs_vec(), lasts, 10'b10000_10000);
    end
    test_frame(8'h01, -1, 0);
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst    = ($urandom_range(0, 149) == 0);
      valid  = ($urandom_range(0, 2) != 0);
      d      = W'($urandom);
      sready = ($urandom_range(0, 3) != 0);
      cycle();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++;
        $display("FAIL random cyc%0d outputs=%b required=%b", cyc, obs_vec(), exp_vec());
      end
    end
    rst = 1'b0; valid = 1'b0; sready = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) cycle();
  endtask

  initial begin
    test_reset();
    test_frame(8'hC1, -1, 0);
    test_frame(8'hC3, -1, 0);
    test_frame(8'hC1, 2, 3);
    test_back_to_back();
    test_reset_midframe();
    test_random();
    test_frame(8'hA6, 5, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/piso_shift_register.md
# piso_shift_register

Parallel-in, serial-out transmitter for the serial link datapath. Accepts one WIDTH-bit word over a valid/ready handshake, then shifts it out one bit per accepted serial beat over a valid/ready serial interface. Sits between a loadable word source (e.g. a `register` stage) and a bit-serial sink.

## Interface

Parameters:
- `WIDTH`, 32: word width in bits; legal range ≥ 2.
- `MSB_FIRST`, 1: 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first.

Ports:
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst_n`  input  1  one clock; reset is synchronous and active-high (despite the name, the block is in reset while `rst_n` = 1).
- `valid_i`  input  1  parallel word offered.
- `d_i`  input  WIDTH  parallel word.
- `ready_o`  output  1  block can accept a word this cycle.
- `sdata_o`  output  1  current serial bit.
- `svalid_o`  output  1  `sdata_o` is valid.
- `sready_i`  input  1  sink accepts the current bit this cycle.
- `last_o`  output  1  the current serial bit is the final bit of the frame.
- `busy_o`  output  1  a frame is in progress (state ≠ IDLE).

## Operation

- Internal state: FSM `state`, shift register `shreg[WIDTH-1:0]`, bit counter `cnt` of width `$clog2(WIDTH)`.
- FSM states: IDLE, SHIFT, and PARITY (PARITY exists only with the macro; see Configuration).
- IDLE:
  - `ready_o` = 1; `svalid_o`, `sdata_o`, `last_o` and `busy_o` = 0.
  - On `valid_i && ready_o`: `shreg` <= `d_i`, `cnt` <= 0, go to SHIFT.
- SHIFT:
  - `svalid_o` = 1, `busy_o` = 1, `ready_o` = 0.
  - `sdata_o` = `shreg[WIDTH-1]` if `MSB_FIRST`, else `shreg[0]`.
  - On `sready_i`: shift toward the output end (left if MSB_FIRST, right otherwise, zero-fill) and `cnt` <= `cnt` + 1.
  - Without `sready_i`: `sdata_o`, `cnt` and `shreg` hold.
  - When `cnt` == WIDTH-1 and `sready_i`: go to IDLE, or to PARITY if the macro is enabled.
- `last_o` = 1 while in SHIFT with `cnt` == WIDTH-1 (macro off), or while in PARITY (macro on).
- `valid_i` is ignored outside IDLE. The source must hold `valid_i` and `d_i` until `ready_o` is seen.
- `cnt` never wraps within a frame. It is reloaded to 0 at every capture.
- Reset (any state, including mid-frame): `state` <= IDLE, `shreg` <= 0, `cnt` <= 0. Any partial frame is discarded and no `last_o` is produced for it.
- `ready_o` is forced to 0 while `rst_n` = 1.

## Timing

- Reset values (the cycle after reset is sampled):
  - `ready_o` = 1
  - `svalid_o` = 0, `sdata_o` = 0, `last_o` = 0, `busy_o` = 0
- Capture at edge N; the first bit is presented on `sdata_o`/`svalid_o` in cycle N+1.
- A bit transfers on each rising edge where `svalid_o && sready_i`.
- With `sready_i` held high, a frame occupies WIDTH cycles (WIDTH+1 with parity). It is followed by one mandatory IDLE cycle before the next capture.
  - Minimum word period: WIDTH+1 cycles (WIDTH+2 with parity).
- `ready_o`, `svalid_o`, `sdata_o`, `last_o` and `busy_o` are functions of registered state only. There is no combinational path from `valid_i` or `sready_i` to any output.

## Configuration

- `PISO_PARITY_EN` defined:
  - At capture, even parity `^d_i` is stored in a 1-bit register.
  - After the last data bit is accepted, the FSM enters PARITY: `sdata_o` = stored parity, `svalid_o` = 1, `last_o` = 1.
  - On `sready_i`, the FSM returns to IDLE.
  - Reset clears the parity register.
- `PISO_PARITY_EN` undefined: the PARITY state and the parity register do not exist, and `last_o` accompanies data bit WIDTH-1.

## Test plan

- WIDTH=8, MSB_FIRST=1, `sready_i`=1, send 0xC1 -> `sdata_o` = 1,1,0,0,0,0,0,1 on consecutive cycles starting one cycle after capture; `last_o` only on the 8th bit; `ready_o` returns to 1 the following cycle.
- WIDTH=8, MSB_FIRST=0, send 0xC1 -> `sdata_o` = 1,0,0,0,0,0,1,1; `last_o` on the 8th bit.
- Send 0xC1 with `sready_i` low for 3 cycles after bit 2 -> `sdata_o` holds 0 and `svalid_o` stays 1 during the stall; the frame completes in 11 cycles with the bit order unchanged.
- Hold `valid_i`=1 with 0x55 offered during a 0xC1 frame -> 0x55 is not captured until the cycle after 0xC1's last bit, then 0x55 is shifted out intact.
- Assert `rst_n` for 1 cycle after 3 bits of 0xFF -> next cycle all outputs are 0 except `ready_o`=1, no `last_o` is seen; a subsequent send of 0x01 yields 0,0,0,0,0,0,0,1.
- `PISO_PARITY_EN` defined, send 0xC1 -> 8 data bits followed by parity bit 1 with `last_o`; send 0xC3 -> parity bit 0; `last_o` is never asserted on a data bit.
